elbeth_decode_queue: RTL and testbench
======================================

# elbeth_decode_queue

Parametrised decode stage for the ELBETH RV32I core, sitting between fetch and execute. Each instruction word accepted from fetch is decoded in the cycle it is accepted. The decoded record (register addresses, immediate, ALU/branch ops, CSR command, exception cause) is pushed into a DEPTH-entry FIFO. Execute pops records through a valid/ready handshake. This decouples fetch stalls from execute stalls, and the FIFO is cleared by a pipeline flush.

## Interface
Parameters:
- XLEN, 32: datapath width; immediates are sign-extended to XLEN (32 or 64).
- DEPTH, 4: FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH): pointer width (derived).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all entries and the current input.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- csr_prv  in  2  current privilege (0=U, 1=S, 3=M).
- out_valid  out  1  head record valid.
- out_ready  in  1  execute consumes the head.
- out_pc  out  XLEN  pc of record.
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  5 each  register fields.
- out_imm  out  XLEN  sign-extended immediate; the shamt for shifts; zimm for CSR*I instructions.
- out_op_alu  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
- out_op_branch  out  4  NONE=0 BEQ=1 BNE=2 BLT=3 BGE=4 BLTU=5 BGEU=6 JAL=7 JALR=8.
- out_except  out  1  record carries an exception.
- out_except_src  out  4  0 none, 2 illegal, 3 EBREAK, 8+csr_prv ECALL.
- out_csr_cmd  out  2  0 none, 1 write, 2 set, 3 clear.
- out_csr_addr  out  12  CSR address.
- count  out  PTR_W+1  current occupancy.

## Operation
- Push when in_valid && in_ready && !flush. The record is decoded from in_instr and the csr_prv value present in that cycle.
- Pop when out_valid && out_ready && !flush.
- in_ready = (count != DEPTH), purely from registered state; no same-cycle bypass when full.
- Push and pop in the same cycle: count unchanged, and both pointers advance modulo DEPTH.
- Illegal conditions (out_except=1, src=2):
  - unknown opcode;
  - bits[1:0] != 2'b11;
  - invalid funct3/funct7 combination;
  - SYSTEM with funct3=0 other than ECALL/EBREAK/MRET.
- Illegal records still carry pc and instr fields; all ops are forced to ADD/NONE and csr_cmd to 0.
- LUI/AUIPC: imm = {instr[31:12],12'b0} sign-extended. Stores use S-type, branches B-type, JAL J-type. ALU defaults to ADD for loads, stores and jumps.
- flush:
  - count, both pointers and out_valid go to 0 next cycle;
  - input in the same cycle is dropped;
  - in_ready is 1 the cycle after.
- Record storage is not cleared by flush or reset; only valid state is cleared.

## Timing
- Reset (rst=1 at edge): count=0, pointers=0, out_valid=0, in_ready=1. All out_* data fields read as 0 while out_valid=0; data outputs are masked by out_valid.
- Latency: instruction accepted at edge N appears at the head (out_valid=1) after edge N, when the queue was empty. Minimum latency is 1 cycle; there is no combinational in→out path.
- Throughput: 1 record/cycle sustained when out_ready is held high.
- out_valid and head data stay stable until popped; execute may hold out_ready low indefinitely.
- rst has priority over flush; flush has priority over push and pop.
- Reset mid-stream loses all entries, identical to flush.

## Configuration
- ELBETH_DECODE_CSR_EN defined:
  - SYSTEM funct3 ∈ {1,2,3,5,6,7} decodes to csr_cmd 1/2/3, with csr_addr = instr[31:20].
  - Illegal if csr_addr[9:8] > csr_prv.
  - Illegal if csr_addr[11:10]==2'b11 and the op writes. CSRRS/CSRRC with rs1/zimm=0 does not write.
- Not defined: all SYSTEM funct3 != 0 are illegal (src=2); out_csr_cmd and out_csr_addr are tied to 0.

## Test plan
- Reset, then push ADDI x1,x0,-1 (0xFFF00093) at pc 0x100 → next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, op_alu=0, except=0.
- Fill DEPTH=4 with out_ready=0 → count=4, in_ready=0. A fifth push is ignored. Then pop all four, which come out in order with matching pcs.
- Continuous push/pop of BEQ x1,x2,+8 (0x00208463) → count constant at 1, op_branch=1, imm=8 every cycle.
- flush asserted with count=3 and in_valid=1 → next cycle count=0, out_valid=0, and the flushed input is never output.
- With CSR_EN, csr_prv=0: CSRRW x1,mstatus(0x300),x2 → except=1, src=2. With csr_prv=3 → csr_cmd=1, csr_addr=0x300, except=0. Without CSR_EN → except=1, src=2.
- ECALL (0x00000073) at csr_prv=3 → src=11. Word 0x00000000 → src=2.

Source files
------------

// File: rtl/elbeth_decode_queue.sv
// RV32I decode stage: decodes each accepted fetch word into a record held in a DEPTH-entry FIFO for execute.
// Optional CSR instruction decode is enabled by defining ELBETH_DECODE_CSR_EN.
module elbeth_decode_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [1:0]       csr_prv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1_addr,
  output logic [4:0]       out_rs2_addr,
  output logic [4:0]       out_rd_addr,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_op_alu,
  output logic [3:0]       out_op_branch,
  output logic             out_except,
  output logic [3:0]       out_except_src,
  output logic [1:0]       out_csr_cmd,
  output logic [11:0]      out_csr_addr,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
  localparam logic [31:0] WORD_MRET   = 32'h3020_0073;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLT  = 4'd3;
  localparam logic [3:0] BR_BGE  = 4'd4;
  localparam logic [3:0] BR_BLTU = 4'd5;
  localparam logic [3:0] BR_BGEU = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_BREAK   = 4'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      op_alu;
    logic [3:0]      op_branch;
    logic            except;
    logic [3:0]      except_src;
    logic [1:0]      csr_cmd;
    logic [11:0]     csr_addr;
  } rec_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt;
  logic            illegal;
  rec_t            dec;
  rec_t            head;
  rec_t            mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = XLEN'($signed(in_instr[31:20]));
  assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign shamt  = XLEN'(in_instr[24:20]);

  // funct3 -> ALU op; alt selects SUB/SRA
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_of = ALU_SLL;
      3'd2:    alu_of = ALU_SLT;
      3'd3:    alu_of = ALU_SLTU;
      3'd4:    alu_of = ALU_XOR;
      3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  // Decode of the word currently offered by fetch
  always_comb begin
    dec           = '0;
    illegal       = 1'b0;
    dec.pc        = in_pc;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.op_alu    = ALU_ADD;
    dec.op_branch = BR_NONE;
    if (in_instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI, OPC_AUIPC: dec.imm = imm_u;
        OPC_JAL: begin
          dec.imm       = imm_j;
          dec.op_branch = BR_JAL;
        end
        OPC_JALR: begin
          dec.imm       = imm_i;
          dec.op_branch = BR_JALR;
          illegal       = (funct3 != 3'd0);
        end
        OPC_BRANCH: begin
          dec.imm = imm_b;
          case (funct3)
            3'd0:    dec.op_branch = BR_BEQ;
            3'd1:    dec.op_branch = BR_BNE;
            3'd4:    dec.op_branch = BR_BLT;
            3'd5:    dec.op_branch = BR_BGE;
            3'd6:    dec.op_branch = BR_BLTU;
            3'd7:    dec.op_branch = BR_BGEU;
            default: illegal = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec.imm = imm_i;
          illegal = (funct3 == 3'd3) || (funct3 >= 3'd6);
        end
        OPC_STORE: begin
          dec.imm = imm_s;
          illegal = (funct3 > 3'd2);
        end
        OPC_OP_IMM: begin
          dec.imm    = ((funct3 == 3'd1) || (funct3 == 3'd5)) ? shamt : imm_i;
          dec.op_alu = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
          if (funct3 == 3'd1) begin
            illegal = (funct7 != 7'h00);
          end else if (funct3 == 3'd5) begin
            illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        end
        OPC_OP: begin
          dec.op_alu = alu_of(funct3, funct7[5]);
          illegal    = !((funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
        end
        OPC_FENCE: begin
          dec.imm = imm_i;
          illegal = (funct3 != 3'd0);
        end
        OPC_SYSTEM: begin
          if (funct3 == 3'd0) begin
            if (in_instr == WORD_ECALL) begin
              dec.except     = 1'b1;
              dec.except_src = {2'b10, csr_prv};
            end else if (in_instr == WORD_EBREAK) begin
              dec.except     = 1'b1;
              dec.except_src = EXC_BREAK;
            end else if (in_instr != WORD_MRET) begin
              illegal = 1'b1;
            end
          end else begin
`ifdef ELBETH_DECODE_CSR_EN
            dec.csr_cmd  = funct3[1:0];
            dec.csr_addr = in_instr[31:20];
            dec.imm      = funct3[2] ? XLEN'(in_instr[19:15]) : imm_i;
            // Set/clear with a zero source leaves the CSR untouched, so read-only CSRs allow it
            if ((funct3[1:0] == 2'b00) || (in_instr[29:28] > csr_prv)) begin
              illegal = 1'b1;
            end else if ((in_instr[31:30] == 2'b11) &&
                         ((funct3[1:0] == 2'b01) || (in_instr[19:15] != 5'd0))) begin
              illegal = 1'b1;
            end
`else
            illegal = 1'b1;
`endif
          end
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) begin
      dec.op_alu     = ALU_ADD;
      dec.op_branch  = BR_NONE;
      dec.csr_cmd    = 2'd0;
      dec.except     = 1'b1;
      dec.except_src = EXC_ILLEGAL;
    end
  end

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: ;
    endcase
  end

  // Queue control; reset and flush both drop every entry
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Record storage carries no reset; validity lives in the control state above
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= dec;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_pc         = head.pc;
  assign out_rs1_addr   = head.rs1;
  assign out_rs2_addr   = head.rs2;
  assign out_rd_addr    = head.rd;
  assign out_imm        = head.imm;
  assign out_op_alu     = head.op_alu;
  assign out_op_branch  = head.op_branch;
  assign out_except     = head.except;
  assign out_except_src = head.except_src;
  assign out_csr_cmd    = head.csr_cmd;
  assign out_csr_addr   = head.csr_addr;

endmodule

// File: tb/tb_elbeth_decode_queue.sv
// Bench for elbeth_decode_queue: directed scenarios then random traffic against a queue-based decode model.
// Build with ELBETH_DECODE_CSR_EN defined to exercise the CSR decode variant.
module tb_elbeth_decode_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc, out_pc, out_imm;
  logic [1:0]        csr_prv, out_csr_cmd;
  logic [4:0]        out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [3:0]        out_op_alu, out_op_branch, out_except_src;
  logic              out_except;
  logic [11:0]       out_csr_addr;
  logic [PTR_W:0]    count;

  always #5 clk = ~clk;

  elbeth_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .csr_prv(csr_prv),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_imm(out_imm), .out_op_alu(out_op_alu), .out_op_branch(out_op_branch),
    .out_except(out_except), .out_except_src(out_except_src),
    .out_csr_cmd(out_csr_cmd), .out_csr_addr(out_csr_addr), .count(count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [3:0]  br;
    logic        ex;
    logic [3:0]  src;
    logic [1:0]  cmd;
    logic [11:0] caddr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected record from the instruction tables
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input logic [1:0] prv);
    exp_t       r;
    bit         ill;
    logic [2:0] f3;
    logic [6:0] f7;
    int         base_alu [8];
    base_alu = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = w[14:12];
    f7 = w[31:25];
    r = '0;
    ill = 1'b0;
    r.pc = pc; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    if (w[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (w[6:0])
        7'b0110111, 7'b0010111: r.imm = {w[31:12], 12'h000};
        7'b1101111: begin r.br = 7; r.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
        7'b1100111: begin r.br = 8; r.imm = {{20{w[31]}}, w[31:20]}; ill = (f3 != 0); end
        7'b1100011: begin
          r.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
          case (f3)
            0: r.br = 1;  1: r.br = 2;  4: r.br = 3;
            5: r.br = 4;  6: r.br = 5;  7: r.br = 6;
            default: ill = 1'b1;
          endcase
        end
        7'b0000011: begin r.imm = {{20{w[31]}}, w[31:20]}; ill = !(f3 inside {0, 1, 2, 4, 5}); end
        7'b0100011: begin r.imm = {{20{w[31]}}, w[31:25], w[11:7]}; ill = (f3 > 2); end
        7'b0010011: begin
          r.imm = {{20{w[31]}}, w[31:20]};
          r.alu = 4'(base_alu[f3]);
          if (f3 == 1) begin r.imm = 32'(w[24:20]); ill = (f7 != 0); end
          if (f3 == 5) begin
            r.imm = 32'(w[24:20]);
            if (f7 == 7'h20) r.alu = 7;
            else if (f7 != 0) ill = 1'b1;
          end
        end
        7'b0110011: begin
          if (f7 == 0) r.alu = 4'(base_alu[f3]);
          else if (f7 == 7'h20 && f3 == 0) r.alu = 1;
          else if (f7 == 7'h20 && f3 == 5) r.alu = 7;
          else ill = 1'b1;
        end
        7'b0001111: begin r.imm = {{20{w[31]}}, w[31:20]}; ill = (f3 != 0); end
        7'b1110011: begin
          if (f3 == 0) begin
            if (w == 32'h0000_0073)      begin r.ex = 1; r.src = 4'(8 + prv); end
            else if (w == 32'h0010_0073) begin r.ex = 1; r.src = 3; end
            else if (w != 32'h3020_0073) ill = 1'b1;
          end else begin
`ifdef ELBETH_DECODE_CSR_EN
            begin : csr_model
              bit wr;
              r.cmd   = f3[1:0];
              r.caddr = w[31:20];
              r.imm   = (f3 >= 5) ? 32'(w[19:15]) : {{20{w[31]}}, w[31:20]};
              wr = (f3 == 1) || (f3 == 5) || (w[19:15] != 0);
              if (f3 == 4) ill = 1'b1;
              if (w[29:28] > prv) ill = 1'b1;
              if (w[31:30] == 2'b11 && wr) ill = 1'b1;
            end
`else
            ill = 1'b1;
`endif
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      r.alu = 0; r.br = 0; r.cmd = 0; r.ex = 1; r.src = 2;
    end
    return r;
  endfunction

  task automatic compare_all();
    exp_t e;
    e = '0;
    if (q.size() != 0) e = q[0];
    check("count", count, q.size());
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() < DEPTH);
    check("out_pc", out_pc, e.pc);
    check("out_rs1", out_rs1_addr, e.rs1);
    check("out_rs2", out_rs2_addr, e.rs2);
    check("out_rd", out_rd_addr, e.rd);
    check("out_op_alu", out_op_alu, e.alu);
    check("out_op_branch", out_op_branch, e.br);
    check("out_except", out_except, e.ex);
    check("out_except_src", out_except_src, e.src);
    check("out_csr_cmd", out_csr_cmd, e.cmd);
    if (!e.ex) begin
      check("out_imm", out_imm, e.imm);
      check("out_csr_addr", out_csr_addr, e.caddr);
    end
  endtask

  // Drive one cycle at the falling edge, advance the model, check at the next falling edge
  task automatic step(input bit rs, input bit fl, input bit v, input logic [31:0] w,
                      input logic [31:0] pc, input logic [1:0] prv, input bit rdy);
    bit push, pop;
    rst = rs; flush = fl; in_valid = v; in_instr = w; in_pc = pc; csr_prv = prv; out_ready = rdy;
    push = v && (q.size() < DEPTH) && !fl && !rs;
    pop  = (q.size() != 0) && rdy && !fl && !rs;
    if (rs || fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ref_decode(w, pc, prv));
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic [11:0] csrs [7];
    csrs = '{12'h300, 12'h100, 12'h001, 12'hC00, 12'h7C0, 12'h341, 12'h000};
    csrs[6] = 12'($urandom);
    w = $urandom; f3 = 3'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 11))
      1:  w = {f7, w[24:20], rs1, f3, rd, 7'b0010011};
      2:  w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      3:  w = {w[31:20], rs1, f3, rd, 7'b0000011};
      4:  w = {w[31:25], rs2, rs1, f3, w[11:7], 7'b0100011};
      5:  w = {w[31:25], rs2, rs1, f3, w[11:7], 7'b1100011};
      6:  w = {w[31:12], rd, 7'b1101111};
      7:  w = {w[31:20], rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'b1100111};
      8:  w = {w[31:12], rd, ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111};
      9: begin
        case ($urandom_range(0, 5))
          0: w = 32'h0000_0073;
          1: w = 32'h0010_0073;
          2: w = 32'h3020_0073;
          3: w = {w[31:15], 3'd0, rd, 7'b1110011};
          default: w = {csrs[$urandom_range(0, 6)], ($urandom_range(0, 1) == 0) ? 5'd0 : rs1,
                        f3, rd, 7'b1110011};
        endcase
      end
      10: w = {w[31:15], ($urandom_range(0, 1) == 0) ? 3'd0 : f3, rd, 7'b0001111};
      11: w[1:0] = 2'($urandom_range(0, 2));
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int rdy_bias;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; csr_prv = 2'd3; out_ready = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 32'h0, 32'h0, 3, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);

    // ADDI x1,x0,-1
    step(0, 0, 1, 32'hFFF0_0093, 32'h100, 3, 1);
    check("addi_valid", out_valid, 1);
    check("addi_rd", out_rd_addr, 1);
    check("addi_rs1", out_rs1_addr, 0);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    check("addi_alu", out_op_alu, 0);
    check("addi_except", out_except, 0);
    step(0, 0, 0, 32'h0, 32'h0, 3, 1);

    // Fill, overflow attempt, then drain in order
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h13 | (32'(i) << 7), 32'h100 + 32'(4 * i), 3, 0);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    step(0, 0, 1, 32'h0050_0093, 32'h200, 3, 0);
    check("fifth_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      check("order_pc", out_pc, 32'h100 + 32'(4 * i));
      step(0, 0, 0, 32'h0, 32'h0, 3, 1);
    end
    check("drained_count", count, 0);

    // Sustained BEQ x1,x2,+8
    step(0, 0, 1, 32'h0020_8463, 32'h300, 3, 1);
    for (int i = 1; i < 9; i++) begin
      step(0, 0, 1, 32'h0020_8463, 32'h300 + 32'(4 * i), 3, 1);
      check("beq_count", count, 1);
      check("beq_branch", out_op_branch, 1);
      check("beq_imm", out_imm, 8);
    end
    step(0, 0, 0, 32'h0, 32'h0, 3, 1);

    // Flush with three entries and a concurrent push
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0000_0013, 32'h400 + 32'(4 * i), 3, 0);
    step(0, 1, 1, 32'h0010_0113, 32'hBAD0, 3, 0);
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 32'h0, 3, 1);
      check("flushed_gone", out_valid, 0);
    end

    // CSRRW x1,mstatus,x2 at U and M privilege
    step(0, 0, 1, 32'h3001_10F3, 32'h500, 0, 1);
`ifdef ELBETH_DECODE_CSR_EN
    check("csr_u_except", out_except, 1);
    check("csr_u_src", out_except_src, 2);
    step(0, 0, 1, 32'h3001_10F3, 32'h504, 3, 1);
    check("csr_m_except", out_except, 0);
    check("csr_m_cmd", out_csr_cmd, 1);
    check("csr_m_addr", out_csr_addr, 12'h300);
`else
    check("csr_off_except", out_except, 1);
    check("csr_off_src", out_except_src, 2);
    step(0, 0, 1, 32'h3001_10F3, 32'h504, 3, 1);
    check("csr_off_m_except", out_except, 1);
    check("csr_off_m_cmd", out_csr_cmd, 0);
`endif
    step(0, 0, 1, 32'h0000_0073, 32'h508, 3, 1);
    check("ecall_except", out_except, 1);
    check("ecall_src", out_except_src, 11);
    step(0, 0, 1, 32'h0000_0000, 32'h50C, 3, 1);
    check("zero_except", out_except, 1);
    check("zero_src", out_except_src, 2);
    step(0, 0, 0, 32'h0, 32'h0, 3, 1);

    // Random traffic with occasional flush and reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_bias = (cyc / 250) % 4;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, gen_instr(), {$urandom, 2'b00} & 32'hFFFF_FFFC,
           2'($urandom), $urandom_range(0, 3) < rdy_bias);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
